// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter feeding one shared bitwise logic unit for three requesters.
// Latency: grant one cycle after request sample, result valid the cycle after; held until res_ready.
module logic_unit_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       req,
  input  logic [2:0]       op0,
  input  logic [2:0]       op1,
  input  logic [2:0]       op2,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] a2,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] b1,
  input  logic [WIDTH-1:0] b2,
  output logic [2:0]       gnt,
  output logic [WIDTH-1:0] res,
  output logic [1:0]       res_id,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       p_q, p_d;
  logic [1:0]       id_q, id_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [1:0]       res_id_q, res_id_d;
  logic [1:0]       win;

  // Scan from the highest offset down so the requester closest to p wins.
  function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] p);
    logic [2:0] s;
    logic [1:0] k;
    rr_pick = p;
    for (int i = 2; i >= 0; i--) begin
      s = {1'b0, p} + 3'(i);
      k = (s >= 3'd3) ? 2'(s - 3'd3) : 2'(s);
      if (r[k]) rr_pick = k;
    end
  endfunction

  function automatic logic [WIDTH-1:0] lu(input logic [2:0] op,
                                          input logic [WIDTH-1:0] a,
                                          input logic [WIDTH-1:0] b);
    case (op)
      3'd0:    lu = a & b;
      3'd1:    lu = a | b;
      3'd2:    lu = ~a;
      3'd3:    lu = ~b;
      3'd4:    lu = ~(a & b);
      3'd5:    lu = ~(a | b);
      3'd6:    lu = a ^ b;
      default: lu = ~(a ^ b);
    endcase
  endfunction

  assign win = rr_pick(req, p_q);

  always_comb begin
    state_d  = state_q;
    p_d      = p_q;
    id_d     = id_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    res_id_d = res_id_q;
    case (state_q)
      IDLE: begin
        if (req != 3'b000) begin
          id_d    = win;
          p_d     = (win == 2'd2) ? 2'd0 : win + 2'd1;
          state_d = EXEC;
          case (win)
            2'd0:    begin op_d = op0; a_d = a0; b_d = b0; end
            2'd1:    begin op_d = op1; a_d = a1; b_d = b1; end
            default: begin op_d = op2; a_d = a2; b_d = b2; end
          endcase
        end
      end
      EXEC: begin
        res_d    = lu(op_q, a_q, b_q);
        res_id_d = id_q;
        state_d  = RESP;
      end
      RESP: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      p_q      <= 2'd0;
      id_q     <= 2'd0;
      op_q     <= 3'd0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      res_id_q <= 2'd0;
    end else begin
      state_q  <= state_d;
      p_q      <= p_d;
      id_q     <= id_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      res_id_q <= res_id_d;
    end
  end

  assign gnt       = (state_q == EXEC) ? (3'b001 << id_q) : 3'b000;
  assign res       = res_q;
  assign res_id    = res_id_q;
  assign res_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Scoreboard bench for logic_unit_arbiter: expected (id, result) pairs are queued when requests are raised.
module tb_logic_unit_arbiter;

  localparam int WIDTH = 8;

  typedef struct {
    logic [1:0] id;
    logic [7:0] res;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [2:0]       req = 3'b000;
  logic [2:0]       op0 = '0, op1 = '0, op2 = '0;
  logic [WIDTH-1:0] a0 = '0, a1 = '0, a2 = '0;
  logic [WIDTH-1:0] b0 = '0, b1 = '0, b2 = '0;
  logic [2:0]       gnt;
  logic [WIDTH-1:0] res;
  logic [1:0]       res_id;
  logic             res_valid;
  logic             res_ready = 1'b1;
  logic             busy;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   last_gnt_cyc = -1;
  bit   spacing_on = 1'b0;
  logic [2:0] g;

  logic_unit_arbiter #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .op0(op0), .op1(op1), .op2(op2),
    .a0(a0), .a1(a1), .a2(a2),
    .b0(b0), .b1(b1), .b2(b2),
    .gnt(gnt), .res(res), .res_id(res_id), .res_valid(res_valid),
    .res_ready(res_ready), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_logic(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return ~a;
      3'd3:    return ~b;
      3'd4:    return ~(a & b);
      3'd5:    return ~(a | b);
      3'd6:    return a ^ b;
      default: return ~(a ^ b);
    endcase
  endfunction

  task automatic push(input logic [1:0] id, input logic [7:0] r);
    exp_t e;
    e.id = id;
    e.res = r;
    exp_q.push_back(e);
  endtask

  // Grant and result monitor
  always @(negedge clk) begin
    if (!spacing_on) last_gnt_cyc = -1;
    if (rst_n) begin
      if (gnt != 3'b000) begin
        check_val("gnt_onehot", $countones(gnt), 1);
        if (exp_q.size() == 0) check_val("gnt_unexpected", {29'd0, gnt}, 0);
        else check_val("gnt_id", {29'd0, gnt}, {29'd0, 3'b001 << exp_q[0].id});
        check_val("gnt_vs_valid", {31'd0, res_valid}, 0);
        if (spacing_on && last_gnt_cyc >= 0) check_val("gnt_spacing", cyc - last_gnt_cyc, 3);
        last_gnt_cyc = cyc;
      end
      if (res_valid) begin
        if (exp_q.size() == 0) begin
          check_val("res_unexpected", {31'd0, res_valid}, 0);
        end else begin
          check_val("res_val", {24'd0, res}, {24'd0, exp_q[0].res});
          check_val("res_id", {30'd0, res_id}, {30'd0, exp_q[0].id});
          if (res_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic wait_gnt(output logic [2:0] got);
    bit found = 1'b0;
    got = 3'b000;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (gnt != 3'b000) begin
        found = 1'b1;
        got = gnt;
      end
    end
    if (!found) check_val("gnt_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    bit found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (!busy) found = 1'b1;
    end
    if (!found) check_val("idle_timeout", 0, 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = 3'b000;
    @(posedge clk);
    @(negedge clk);
    check_val("rst_gnt", {29'd0, gnt}, 0);
    check_val("rst_res", {24'd0, res}, 0);
    check_val("rst_res_id", {30'd0, res_id}, 0);
    check_val("rst_valid", {31'd0, res_valid}, 0);
    check_val("rst_busy", {31'd0, busy}, 0);
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] sweep_tbl [8];
    sweep_tbl = '{8'h88, 8'hEE, 8'h33, 8'h55, 8'h77, 8'h11, 8'h66, 8'h99};

    repeat (2) @(posedge clk);
    #1 do_reset();

    // Single request with exact latency
    op0 = 3'd0; a0 = 8'hCC; b0 = 8'hAA; res_ready = 1'b1;
    req = 3'b001;
    push(2'd0, 8'h88);
    @(negedge clk);
    check_val("lat_gnt_early", {29'd0, gnt}, 0);
    @(negedge clk);
    check_val("single_gnt", {29'd0, gnt}, 3'b001);
    check_val("single_busy_exec", {31'd0, busy}, 1);
    @(posedge clk);
    #1 req = 3'b000;
    @(negedge clk);
    check_val("single_valid", {31'd0, res_valid}, 1);
    check_val("single_gnt_off", {29'd0, gnt}, 0);
    @(negedge clk);
    check_val("single_valid_once", {31'd0, res_valid}, 0);
    check_val("single_idle", {31'd0, busy}, 0);

    // Op sweep on requester 1; operands scrambled after grant must not matter
    for (int i = 0; i < 8; i++) begin
      op1 = 3'(i); a1 = 8'hCC; b1 = 8'hAA;
      req = 3'b010;
      push(2'd1, sweep_tbl[i]);
      wait_gnt(g);
      @(posedge clk);
      #1 req = 3'b000;
      op1 = 3'($urandom); a1 = 8'($urandom); b1 = 8'($urandom);
      wait_idle();
    end

    // Contention: all three held, strict rotation every 3 cycles
    do_reset();
    op0 = 3'd0; a0 = 8'h0F; b0 = 8'h3C;
    op1 = 3'd6; a1 = 8'hF0; b1 = 8'hFF;
    op2 = 3'd5; a2 = 8'h12; b2 = 8'h34;
    for (int r = 0; r < 2; r++) begin
      push(2'd0, ref_logic(op0, a0, b0));
      push(2'd1, ref_logic(op1, a1, b1));
      push(2'd2, ref_logic(op2, a2, b2));
    end
    spacing_on = 1'b1;
    req = 3'b111;
    repeat (6) wait_gnt(g);
    @(posedge clk);
    #1 req = 3'b000;
    wait_idle();
    spacing_on = 1'b0;

    // Fairness after reset with per-grant deassertion
    do_reset();
    op0 = 3'd4; a0 = 8'hA5; b0 = 8'h0F;
    op1 = 3'd1; a1 = 8'h01; b1 = 8'h80;
    op2 = 3'd7; a2 = 8'h5A; b2 = 8'hC3;
    req = 3'b110;
    push(2'd1, ref_logic(op1, a1, b1));
    push(2'd2, ref_logic(op2, a2, b2));
    wait_gnt(g);
    check_val("fair_first", {29'd0, g}, 3'b010);
    @(posedge clk);
    #1 req[1] = 1'b0;
    wait_gnt(g);
    check_val("fair_second", {29'd0, g}, 3'b100);
    @(posedge clk);
    #1 req[2] = 1'b0;
    wait_idle();
    req = 3'b101;
    push(2'd0, ref_logic(op0, a0, b0));
    push(2'd2, ref_logic(op2, a2, b2));
    wait_gnt(g);
    check_val("fair_third", {29'd0, g}, 3'b001);
    @(posedge clk);
    #1 req[0] = 1'b0;
    wait_gnt(g);
    check_val("fair_fourth", {29'd0, g}, 3'b100);
    @(posedge clk);
    #1 req[2] = 1'b0;
    wait_idle();

    // Backpressure in RESP with all requesting
    do_reset();
    res_ready = 1'b0;
    op0 = 3'd2; a0 = 8'h3C; b0 = 8'h00;
    op1 = 3'd3; a1 = 8'h00; b1 = 8'h0F;
    req = 3'b111;
    push(2'd0, ref_logic(op0, a0, b0));
    push(2'd1, ref_logic(op1, a1, b1));
    wait_gnt(g);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_val("bp_valid", {31'd0, res_valid}, 1);
      check_val("bp_gnt", {29'd0, gnt}, 0);
    end
    @(posedge clk);
    #1 res_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_val("bp_idle", {31'd0, busy}, 0);
    wait_gnt(g);
    check_val("bp_next_gnt", {29'd0, g}, 3'b010);
    @(posedge clk);
    #1 req = 3'b000;
    wait_idle();

    // Reset during RESP abandons the transaction
    do_reset();
    res_ready = 1'b0;
    op0 = 3'd1; a0 = 8'h55; b0 = 8'h22;
    req = 3'b001;
    push(2'd0, ref_logic(op0, a0, b0));
    wait_gnt(g);
    @(posedge clk);
    #1 req = 3'b000;
    @(negedge clk);
    check_val("rst_pre_valid", {31'd0, res_valid}, 1);
    #1 do_reset();
    res_ready = 1'b1;
    op1 = 3'd6; a1 = 8'hAB; b1 = 8'hCD;
    req = 3'b010;
    push(2'd1, ref_logic(op1, a1, b1));
    wait_gnt(g);
    check_val("rst_after_gnt", {29'd0, g}, 3'b010);
    @(posedge clk);
    #1 req = 3'b000;
    wait_idle();
    @(negedge clk);

    check_val("sb_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/logic_unit_arbiter.md
LOGIC_UNIT_ARBITER -- requirements
Module: logic_unit_arbiter

Interface
REQ-001 Parameter: WIDTH, 8, operand/result bit width (legal range 1..32).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 Port: req  input  3  request per requester k (k = 0..2), level, held until granted.
REQ-005 Port: op0, op1, op2  input  3 each  operation code of requester k.
REQ-006 Port: a0, a1, a2  input  WIDTH each  operand A of requester k.
REQ-007 Port: b0, b1, b2  input  WIDTH each  operand B of requester k.
REQ-008 Port: gnt  output  3  one-hot grant pulse, at most one bit high.
REQ-009 Port: res  output  WIDTH  registered result.
REQ-010 Port: res_id  output  2  index of the requester owning res.
REQ-011 Port: res_valid  output  1  res/res_id valid.
REQ-012 Port: res_ready  input  1  consumer accepts the result.
REQ-013 Port: busy  output  1  high whenever state is not IDLE.

Function
REQ-014 Op encoding: 0 AND, 1 OR, 2 NOT a, 3 NOT b, 4 NAND, 5 NOR, 6 XOR, 7 XNOR.
REQ-015 All 8 codes are legal; all operations are bitwise across WIDTH bits.
REQ-016 A single shared logic unit serves all requesters.
REQ-017 FSM states: IDLE, EXEC, RESP.
REQ-018 IDLE with req != 0:
  - select the winner by round-robin;
  - latch its op, a, b and index;
  - go to EXEC.
REQ-019 IDLE with req == 0: stay in IDLE.
REQ-020 EXEC lasts exactly one cycle:
  - gnt[winner] = 1 during EXEC only;
  - result computed from the latched operands and registered into res;
  - res_id = winner;
  - go to RESP.
REQ-021 RESP: res_valid = 1; res and res_id held stable until res_valid && res_ready, then go to IDLE.
REQ-022 Latency: request sampled in IDLE at edge N gives gnt high in cycle N+1 and res_valid high from cycle N+2.
REQ-023 Throughput: at most one operation per 3 cycles, even with res_ready tied high.
REQ-024 Round-robin order:
  - priority pointer p resets to 0;
  - search order is p, p+1, p+2 (mod 3);
  - on each grant to k, p becomes (k+1) mod 3.
REQ-025 req is not sampled in EXEC or RESP; changes to req, op, a or b in those states have no effect on the current result.
REQ-026 Requester handshake:
  - the requester deasserts req in the cycle after its gnt pulse;
  - if req is still high when the FSM returns to IDLE, it counts as a new request.
REQ-027 res_ready high outside RESP is ignored.
REQ-028 busy = 1 in EXEC and RESP; busy = 0 in IDLE.

Reset
REQ-029 When rst_n = 0 at a clock edge, from the next cycle:
  - state = IDLE, p = 0;
  - gnt = 0, res = 0, res_id = 0, res_valid = 0, busy = 0.
REQ-030 Reset asserted in EXEC or RESP abandons the transaction; no further gnt or res_valid is produced for it.
REQ-031 Reset has priority over all other inputs.

Verification (WIDTH = 8)
REQ-032 Single request: req = 001, op0 = 0, a0 = 0xCC, b0 = 0xAA, res_ready = 1 -> gnt = 001 for exactly one cycle; one cycle later res = 0x88, res_id = 0, res_valid = 1 for one cycle.
REQ-033 Op sweep: requester 1, a1 = 0xCC, b1 = 0xAA, op1 = 0..7 -> res = 0x88, 0xEE, 0x33, 0x55, 0x77, 0x11, 0x66, 0x99 in order.
REQ-034 Contention: req = 111 held continuously, res_ready = 1 -> grant sequence 0, 1, 2, 0, 1, 2 with exactly 3 cycles between grants.
REQ-035 Fairness after reset, with each granted requester deasserting req the cycle after its gnt:
  - req = 110 -> requester 1 granted first, then 2;
  - req = 101 raised afterwards -> requester 0 granted (p = 0 after granting 2), then 2.
REQ-036 Backpressure: res_ready = 0 for 5 cycles while in RESP, with req = 111 -> res/res_id stable, res_valid high, gnt = 000 throughout; res_ready = 1 -> handshake completes, IDLE next cycle, next grant follows.
REQ-037 Reset mid-operation: rst_n = 0 during RESP -> next cycle all outputs 0 and busy = 0; after release with req = 010, requester 1 is granted (p = 0, requester 0 not requesting).
